word_arith_checker: RTL and testbench
=====================================

# word_arith_checker

Receive-side checker for the word-arithmetic regression device. It sits on the device's output and consumes each stimulus word together with the device's Maybe-encoded response. It recomputes the expected value with a multi-cycle iterative datapath and keeps saturating pass/error/skip counters plus a snapshot of the last mismatch. It is used in regression harnesses and FPGA self-test wrappers.

## Interface
- CNT_W, 16, width of the checked/error/skipped counters
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  stimulus/response pair offered
- s_ready  out  1  checker idle and able to accept
- s_stim  in  8  stimulus word x applied to the device
- s_resp  in  9  device response: bit 8 = Just flag, bits 7:0 = data
- busy  out  1  computation in progress
- err_pulse  out  1  one-cycle pulse on a detected mismatch
- cnt_checked  out  CNT_W  pairs compared; includes mismatches, excludes skips
- cnt_errors  out  CNT_W  mismatches
- cnt_skipped  out  CNT_W  pairs not compared
- last_err_stim  out  8  x of the most recent mismatch
- last_err_exp  out  8  expected data of the most recent mismatch
- last_err_got  out  8  received data of the most recent mismatch

## Operation
- Expected function uses 8-bit modular arithmetic throughout; every intermediate is truncated to 8 bits: f(x) = ((((x+1)·(x+1)) · (x−2)) / 3) mod (x+1).
  - Unsigned truncating division.
  - x−2 wraps.
- FSM states:
  - IDLE: s_ready=1. On s_valid&&s_ready, latch s_stim and s_resp. Go to CMP if x==8'hFF (divisor x+1 is zero), otherwise go to SQR.
  - SQR: 8-cycle shift-add multiply, a=(x+1)·(x+1).
  - MUL: 8-cycle shift-add multiply, b=a·(x−2).
  - DIV: 8-cycle restoring divide, c=b/3.
  - MOD: 8-cycle restoring divide, e=c mod (x+1), taken from the remainder.
  - CMP: 1 cycle, then return to IDLE.
- CMP rules, evaluated in this order:
  - If x==8'hFF: cnt_skipped+1; nothing else changes.
  - Else if s_resp[8]==0 or s_resp[7:0]!=e: cnt_checked+1, cnt_errors+1, err_pulse. last_err_stim/exp/got are loaded with x, e and s_resp[7:0].
  - Else: cnt_checked+1.
- Counters saturate at all-ones and never wrap.
- s_valid is ignored outside IDLE. Latched operands are stable for the whole computation; s_stim and s_resp may change after acceptance.
- busy = (state != IDLE).

## Timing
- Reset (async assert, sync release inside the block):
  - All counters, last_err_* and err_pulse are 0.
  - State is IDLE.
  - s_ready is held 0 while rst is high and is 1 in the first cycle after release.
- Acceptance at the edge ending cycle T:
  - SQR occupies T+1..T+8.
  - MUL occupies T+9..T+16.
  - DIV occupies T+17..T+24.
  - MOD occupies T+25..T+32.
  - CMP occupies T+33.
- Counter, last_err_* and err_pulse updates are registered and become visible in T+34. err_pulse is high for exactly cycle T+34. s_ready is 1 again in T+34.
- Skip path: CMP occupies T+1; cnt_skipped is visible and s_ready returns in T+2.
- Maximum throughput is one compared pair per 34 cycles.
- Reset mid-computation abandons the pair with no counter update.
- Counter at saturation plus another event: the value holds, and err_pulse still fires for a mismatch.

## Structure
- Package word_arith_pkg:
  - state enum: IDLE, SQR, MUL, DIV, MOD, CMP
  - constants: ADD_K=8'd1, SUB_K=8'd2, DIV_K=8'd3, SKIP_STIM=8'hFF, ITER_N=8
  - Maybe-word field positions: flag bit 8, data 7:0
- Sub-module word_arith_divu8: 8-bit iterative restoring divider.
  - Start/done handshake; 8 cycles per operation; quotient and remainder outputs.
  - Instantiated once and reused for both DIV and MOD.
  - Divisor zero is never presented to it.
- The shift-add multiplier is implemented inline in the top FSM.

## Test plan
- x=8'd7, resp=9'h105 (f(7) = 64·5 = 320→64, /3=21, mod 8 = 5):
  - err_pulse stays 0.
  - cnt_checked=1, cnt_errors=0.
  - s_ready returns at T+34.
- x=8'd7, resp=9'h104:
  - err_pulse high at T+34.
  - cnt_errors=1.
  - last_err_stim=07, last_err_exp=05, last_err_got=04.
- x=8'd0, resp=9'h000 (correct data, flag clear): error counted, last_err_exp=00, last_err_got=00. Then x=8'd5 with resp=9'h100 passes.
- x=8'hFF, any resp:
  - cnt_skipped=1, cnt_checked unchanged.
  - s_ready returns at T+2.
- Assert rst at T+20 of a pair in flight:
  - All outputs 0 immediately.
  - After release, s_ready=1 and the next pair x=7/9'h105 checks cleanly.
- CNT_W=4, 17 back-to-back failing pairs with s_valid held high:
  - cnt_checked and cnt_errors saturate at 15.
  - 17 err_pulses are observed, spaced exactly 34 cycles apart.

Source files
------------

// File: rtl/word_arith_pkg.sv
// Shared types and constants for the word-arithmetic response checker.
package word_arith_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SQR,
    MUL,
    DIV,
    MOD,
    CMP
  } state_t;

  localparam logic [7:0] ADD_K     = 8'd1;
  localparam logic [7:0] SUB_K     = 8'd2;
  localparam logic [7:0] DIV_K     = 8'd3;
  localparam logic [7:0] SKIP_STIM = 8'hFF;

  localparam int ITER_N = 8;
  localparam logic [2:0] ITER_LAST = 3'(ITER_N - 1);

  // Maybe-encoded response word: Just flag above an 8-bit payload
  localparam int FLAG_BIT = 8;
  localparam int DATA_MSB = 7;

endpackage

// File: rtl/word_arith_divu8.sv
// 8-bit iterative restoring divider, one quotient bit per cycle.
// The start cycle already performs the first step, so a result is
// ready in the cycle after done is high (8 cycles from start).
module word_arith_divu8
  import word_arith_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quot,
  output logic [7:0] rem,
  output logic       done
);

  logic [7:0] q_r, r_r, d_r;
  logic [2:0] cnt;
  logic [7:0] step_q, step_r, step_d;
  logic [8:0] trial, diff;
  logic [7:0] q_nxt, r_nxt;

  // One restoring step on either fresh operands (start) or the running state
  always_comb begin
    step_q = start ? dividend : q_r;
    step_r = start ? 8'd0 : r_r;
    step_d = start ? divisor : d_r;
    trial  = {step_r, step_q[7]};
    diff   = trial - {1'b0, step_d};
    if (trial >= {1'b0, step_d}) begin
      r_nxt = diff[7:0];
      q_nxt = {step_q[6:0], 1'b1};
    end else begin
      r_nxt = trial[7:0];
      q_nxt = {step_q[6:0], 1'b0};
    end
  end

  // Iteration registers; cnt counts the steps still outstanding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 8'd0;
      r_r <= 8'd0;
      d_r <= 8'd0;
      cnt <= 3'd0;
    end else if (start) begin
      q_r <= q_nxt;
      r_r <= r_nxt;
      d_r <= divisor;
      cnt <= ITER_LAST;
    end else if (cnt != 3'd0) begin
      q_r <= q_nxt;
      r_r <= r_nxt;
      cnt <= cnt - 3'd1;
    end
  end

  assign quot = q_r;
  assign rem  = r_r;
  assign done = (cnt == 3'd1);

endmodule

// File: rtl/word_arith_checker.sv
// Receive-side checker: recomputes f(x) = ((((x+1)^2)*(x-2))/3) mod (x+1)
// in 8-bit arithmetic over 33 cycles and compares it with the device response.
module word_arith_checker
  import word_arith_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_stim,
  input  logic [8:0]       s_resp,
  output logic             busy,
  output logic             err_pulse,
  output logic [CNT_W-1:0] cnt_checked,
  output logic [CNT_W-1:0] cnt_errors,
  output logic [CNT_W-1:0] cnt_skipped,
  output logic [7:0]       last_err_stim,
  output logic [7:0]       last_err_exp,
  output logic [7:0]       last_err_got
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic [7:0] x_q;
  logic [8:0] resp_q;
  logic [2:0] iter;
  logic [7:0] mul_acc, mul_cand, mul_plier, mul_acc_nxt;
  logic       accept, mismatch;
  logic       div_start, div_done;
  logic [7:0] div_dividend, div_divisor, div_quot, div_rem;

  assign accept      = s_valid && s_ready;
  assign mul_acc_nxt = mul_acc + (mul_plier[0] ? mul_cand : 8'd0);
  assign mismatch    = !resp_q[FLAG_BIT] || (resp_q[DATA_MSB:0] != div_rem);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: multiplies are timed by iter, divides by the divider's done
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (s_stim == SKIP_STIM) ? CMP : SQR;
      SQR:  if (iter == 3'd0) state_nxt = MUL;
      MUL:  if (iter == 3'd0) state_nxt = DIV;
      DIV:  if (div_done) state_nxt = MOD;
      MOD:  if (div_done) state_nxt = CMP;
      CMP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs and divider operand steering (b/3 first, then c mod (x+1))
  always_comb begin
    s_ready      = (state == IDLE) && !rst;
    busy         = (state != IDLE);
    div_start    = ((state == DIV) || (state == MOD)) && (iter == ITER_LAST);
    div_dividend = (state == MOD) ? div_quot : mul_acc;
    div_divisor  = (state == MOD) ? (x_q + ADD_K) : DIV_K;
  end

  // Operand latch, iteration down-counter and inline shift-add multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= 8'd0;
      resp_q    <= 9'd0;
      iter      <= 3'd0;
      mul_acc   <= 8'd0;
      mul_cand  <= 8'd0;
      mul_plier <= 8'd0;
    end else begin
      if ((state == SQR) || (state == MUL) || (state == DIV) || (state == MOD))
        iter <= (iter == 3'd0) ? ITER_LAST : iter - 3'd1;
      case (state)
        IDLE: if (accept) begin
          x_q       <= s_stim;
          resp_q    <= s_resp;
          iter      <= ITER_LAST;
          mul_acc   <= 8'd0;
          mul_cand  <= s_stim + ADD_K;
          mul_plier <= s_stim + ADD_K;
        end
        SQR: begin
          if (iter == 3'd0) begin
            mul_acc   <= 8'd0;
            mul_cand  <= mul_acc_nxt;
            mul_plier <= x_q - SUB_K;
          end else begin
            mul_acc   <= mul_acc_nxt;
            mul_cand  <= {mul_cand[6:0], 1'b0};
            mul_plier <= {1'b0, mul_plier[7:1]};
          end
        end
        MUL: begin
          mul_acc   <= mul_acc_nxt;
          mul_cand  <= {mul_cand[6:0], 1'b0};
          mul_plier <= {1'b0, mul_plier[7:1]};
        end
        default: ;
      endcase
    end
  end

  // Verdict: saturating counters, error snapshot and the mismatch pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse     <= 1'b0;
      cnt_checked   <= '0;
      cnt_errors    <= '0;
      cnt_skipped   <= '0;
      last_err_stim <= 8'd0;
      last_err_exp  <= 8'd0;
      last_err_got  <= 8'd0;
    end else begin
      err_pulse <= 1'b0;
      if (state == CMP) begin
        if (x_q == SKIP_STIM) begin
          if (cnt_skipped != CNT_MAX) cnt_skipped <= cnt_skipped + CNT_ONE;
        end else begin
          if (cnt_checked != CNT_MAX) cnt_checked <= cnt_checked + CNT_ONE;
          if (mismatch) begin
            if (cnt_errors != CNT_MAX) cnt_errors <= cnt_errors + CNT_ONE;
            err_pulse     <= 1'b1;
            last_err_stim <= x_q;
            last_err_exp  <= div_rem;
            last_err_got  <= resp_q[DATA_MSB:0];
          end
        end
      end
    end
  end

  word_arith_divu8 u_divu8 (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

endmodule

// File: tb/tb_word_arith_checker.sv
// Scoreboard bench for word_arith_checker (built with 4-bit counters so
// saturation is reachable in a short run).
module tb_word_arith_checker;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_stim;
  logic [8:0]       s_resp;
  logic             busy;
  logic             err_pulse;
  logic [CNT_W-1:0] cnt_checked, cnt_errors, cnt_skipped;
  logic [7:0]       last_err_stim, last_err_exp, last_err_got;

  word_arith_checker #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_stim        (s_stim),
    .s_resp        (s_resp),
    .busy          (busy),
    .err_pulse     (err_pulse),
    .cnt_checked   (cnt_checked),
    .cnt_errors    (cnt_errors),
    .cnt_skipped   (cnt_skipped),
    .last_err_stim (last_err_stim),
    .last_err_exp  (last_err_exp),
    .last_err_got  (last_err_got)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       skip;
    logic       err;
    logic [7:0] stim;
    logic [7:0] e;
    logic [7:0] got;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t ent;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_count = 0;
  int pulses = 0;
  int last_pulse = 0;
  bit sat_phase = 1'b0;
  bit prev_busy = 1'b0;
  bit done_now;
  int m_chk, m_err, m_skip;
  logic [7:0] m_ls, m_le, m_lg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] f_model(input logic [7:0] x);
    logic [7:0] p, a, b, c;
    p = x + 8'd1;
    a = p * p;
    b = a * (x - 8'd2);
    c = b / 8'd3;
    return c % p;
  endfunction

  // Monitor: completion is busy falling; acceptance is valid&&ready before an edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      m_chk = 0; m_err = 0; m_skip = 0;
      m_ls = 8'd0; m_le = 8'd0; m_lg = 8'd0;
      pulses = 0;
      prev_busy = 1'b0;
    end else begin
      done_now = prev_busy && !busy;
      if (done_now) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          ent = sb.pop_front();
          if (ent.skip) begin
            if (m_skip != CNT_MAX) m_skip++;
          end else begin
            if (m_chk != CNT_MAX) m_chk++;
            if (ent.err) begin
              if (m_err != CNT_MAX) m_err++;
              m_ls = ent.stim; m_le = ent.e; m_lg = ent.got;
            end
          end
          check("latency", cyc - ent.acc_cyc, ent.skip ? 2 : 34);
          check("err_pulse", err_pulse, ent.err);
          check("cnt_checked", cnt_checked, m_chk);
          check("cnt_errors", cnt_errors, m_err);
          check("cnt_skipped", cnt_skipped, m_skip);
          check("last_err_stim", last_err_stim, m_ls);
          check("last_err_exp", last_err_exp, m_le);
          check("last_err_got", last_err_got, m_lg);
        end
      end else begin
        check("err_pulse_quiet", err_pulse, 0);
      end
      if (err_pulse) begin
        if (sat_phase && pulses > 0) check("pulse_gap", cyc - last_pulse, 34);
        pulses++;
        last_pulse = cyc;
      end
      if (s_valid && s_ready) begin
        ent.stim    = s_stim;
        ent.got     = s_resp[7:0];
        ent.skip    = (s_stim == 8'hFF);
        ent.e       = ent.skip ? 8'd0 : f_model(s_stim);
        ent.err     = !ent.skip && (!s_resp[8] || (s_resp[7:0] != ent.e));
        ent.acc_cyc = cyc;
        sb.push_back(ent);
        acc_count++;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(sb.size() == 0 && s_ready && !busy) && n < budget);
    check("idle_reached", (sb.size() == 0) && s_ready && !busy, 1);
  endtask

  task automatic send(input logic [7:0] x, input logic [8:0] r);
    @(posedge clk); #1;
    s_valid = 1'b1; s_stim = x; s_resp = r;
    @(posedge clk); #1;
    s_valid = 1'b0; s_stim = 8'($urandom); s_resp = 9'($urandom);
    wait_idle(60);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_checked"}, cnt_checked, 0);
    check({tag, "_errors"}, cnt_errors, 0);
    check({tag, "_skipped"}, cnt_skipped, 0);
    check({tag, "_lstim"}, last_err_stim, 0);
    check({tag, "_lexp"}, last_err_exp, 0);
    check({tag, "_lgot"}, last_err_got, 0);
    check({tag, "_pulse"}, err_pulse, 0);
    check({tag, "_ready"}, s_ready, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_stim = 8'd0; s_resp = 9'd0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", s_ready, 1);

    send(8'd7, 9'h105);
    send(8'd7, 9'h104);
    send(8'd0, 9'h000);
    send(8'd5, 9'h100);
    send(8'hFF, 9'($urandom));

    // Reset in the middle of a computation
    @(posedge clk); #1;
    s_valid = 1'b1; s_stim = 8'd7; s_resp = 9'h104;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_midrst", s_ready, 1);
    send(8'd7, 9'h105);

    // Back-to-back failing pairs into the saturating counters
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sat_phase = 1'b1;
    acc_count = 0;
    s_valid = 1'b1; s_stim = 8'd7; s_resp = 9'h104;
    for (int n = 0; n < 17 * 34 + 60 && acc_count < 17; n++) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("sat_accepts", acc_count, 17);
    wait_idle(60);
    check("sat_pulses", pulses, 17);
    check("sat_checked", cnt_checked, 15);
    check("sat_errors", cnt_errors, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
